// File: rtl/codificador_de_usuario.sv
// codificador_de_usuario
// Turns three raw push buttons (Next, Confirm, Cancel) into the 3-bit User
// code for the seven-segment decoder. Each button is synchronised,
// debounced and edge-detected. A select/confirm/cancel state machine then
// steps through the valid user codes only and latches the confirmed one.
// Optional build macro: BLINK_EN. When it is defined, the candidate blinks
// while in SELECT. By default it is undefined and the candidate is shown
// steadily.
module codificador_de_usuario #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int BLINK_CYCLES    = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Next,
  input  logic       Confirm,
  input  logic       Cancel,
  output logic [2:0] User,
  output logic       Selecting,
  output logic       Confirmed,
  output logic       ConfirmPulse
);

  // Terminal counts. Both counters start from zero, so they compare
  // against N-1.
  localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Button bit order used throughout: [0]=Next, [1]=Confirm, [2]=Cancel.
  localparam int B_NEXT    = 0;
  localparam int B_CONFIRM = 1;
  localparam int B_CANCEL  = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SELECT    = 2'd1,
    ST_CONFIRMED = 2'd2
  } state_t;

  // Step through the valid codes only. Any unexpected value restarts the
  // sequence at 001, so 010 and 100 can never appear on User.
  function automatic logic [2:0] next_code(input logic [2:0] code);
    case (code)
      3'b001:  next_code = 3'b011;
      3'b011:  next_code = 3'b101;
      3'b101:  next_code = 3'b110;
      3'b110:  next_code = 3'b111;
      default: next_code = 3'b001;
    endcase
  endfunction

  logic [2:0] raw;
  logic [2:0] sync_p0;
  logic [2:0] sync_p1;
  logic [2:0] deb_p2;
  logic [2:0] deb_p3;
  logic [2:0] evt_p4;
  logic [7:0] db_cnt [3];

  assign raw = {Cancel, Confirm, Next};

  // Button conditioning: synchroniser, debounce, then rising-edge pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb_p2  <= '0;
      deb_p3  <= '0;
      evt_p4  <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      // stage p0/p1: two-flop synchroniser for the asynchronous buttons
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // stage p2: the debounced level follows only a level held for
      // DEBOUNCE_CYCLES consecutive cycles
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb_p2[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
      // stage p3/p4: registered rising-edge detect. Releases give no event.
      deb_p3 <= deb_p2;
      evt_p4 <= deb_p2 & ~deb_p3;
    end
  end

  // Resolve same-cycle events: Cancel beats Confirm beats Next.
  logic ev_cancel;
  logic ev_confirm;
  logic ev_next;

  assign ev_cancel  = evt_p4[B_CANCEL];
  assign ev_confirm = evt_p4[B_CONFIRM] & ~evt_p4[B_CANCEL];
  assign ev_next    = evt_p4[B_NEXT] & ~evt_p4[B_CONFIRM] & ~evt_p4[B_CANCEL];

  state_t      state;
  state_t      state_n;
  logic [2:0]  cand;
  logic [2:0]  cand_n;
  logic [2:0]  latched;
  logic [2:0]  latched_n;
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_n;
  logic [2:0]  user_n;
  logic        sel_n;
  logic        conf_n;
  logic        pulse_n;
  logic        blank_n;

  // Next-state, candidate, latched-code and SELECT timeout logic.
  always_comb begin
    state_n   = state;
    cand_n    = cand;
    latched_n = latched;
    tmo_n     = tmo_cnt;
    case (state)
      ST_IDLE: begin
        if (ev_next) begin
          state_n = ST_SELECT;
          cand_n  = 3'b001;
        end
      end
      ST_SELECT: begin
        if (ev_cancel) begin
          state_n = ST_IDLE;
        end else if (ev_confirm) begin
          latched_n = cand;
          state_n   = ST_CONFIRMED;
        end else if (ev_next) begin
          cand_n = next_code(cand);
          tmo_n  = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n = ST_IDLE;
        end else begin
          tmo_n = tmo_cnt + 16'd1;
        end
      end
      ST_CONFIRMED: begin
        if (ev_cancel) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // The timeout only runs inside SELECT and starts from zero on entry.
    if (state_n != ST_SELECT) begin
      tmo_n = '0;
    end
  end

`ifdef BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_n;
  logic               blink_phase;
  logic               blink_phase_n;

  // Blink phase. It restarts on SELECT entry and on every Next, so a new
  // candidate is visible at once.
  always_comb begin
    blink_cnt_n   = '0;
    blink_phase_n = 1'b0;
    if (state == ST_SELECT && state_n == ST_SELECT && !ev_next) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_n   = '0;
        blink_phase_n = ~blink_phase;
      end else begin
        blink_cnt_n   = blink_cnt + 1'b1;
        blink_phase_n = blink_phase;
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt   <= blink_cnt_n;
      blink_phase <= blink_phase_n;
    end
  end

  assign blank_n = blink_phase_n;
`else
  logic unused_blink;
  assign unused_blink = |BLINK_CYCLES;
  assign blank_n      = 1'b0;
`endif

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    user_n  = 3'b000;
    sel_n   = 1'b0;
    conf_n  = 1'b0;
    pulse_n = 1'b0;
    case (state_n)
      ST_SELECT: begin
        sel_n  = 1'b1;
        user_n = blank_n ? 3'b000 : cand_n;
      end
      ST_CONFIRMED: begin
        conf_n  = 1'b1;
        user_n  = latched_n;
        pulse_n = (state != ST_CONFIRMED);
      end
      default: begin
        user_n = 3'b000;
      end
    endcase
  end

  // State, datapath and registered outputs. Reset overrides any event.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_IDLE;
      cand         <= 3'b001;
      latched      <= 3'b000;
      tmo_cnt      <= '0;
      User         <= 3'b000;
      Selecting    <= 1'b0;
      Confirmed    <= 1'b0;
      ConfirmPulse <= 1'b0;
    end else begin
      state        <= state_n;
      cand         <= cand_n;
      latched      <= latched_n;
      tmo_cnt      <= tmo_n;
      User         <= user_n;
      Selecting    <= sel_n;
      Confirmed    <= conf_n;
      ConfirmPulse <= pulse_n;
    end
  end

endmodule

// File: tb/tb_codificador_de_usuario.sv
// Directed bench for codificador_de_usuario with default parameters
// (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=1000), BLINK_EN undefined.
module tb_codificador_de_usuario;

  logic       clk = 1'b0;
  logic       rst;
  logic       next_b;
  logic       confirm_b;
  logic       cancel_b;
  logic [2:0] user;
  logic       selecting;
  logic       confirmed;
  logic       confirm_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_total   = 0;
  int pulse_outside = 0;
  int bad_code      = 0;
  int exp_pulses    = 0;

  always #5 clk = ~clk;

  codificador_de_usuario dut (
    .Clock       (clk),
    .Reset       (rst),
    .Next        (next_b),
    .Confirm     (confirm_b),
    .Cancel      (cancel_b),
    .User        (user),
    .Selecting   (selecting),
    .Confirmed   (confirmed),
    .ConfirmPulse(confirm_pulse)
  );

  // Background monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (confirm_pulse === 1'b1) begin
      pulse_total++;
      if (confirmed !== 1'b1) pulse_outside++;
    end
    if (user === 3'b010 || user === 3'b100) bad_code++;
  end

  typedef struct {
    logic [2:0] btn;       // {Cancel, Confirm, Next}
    int         hold;
    logic [2:0] exp_user;
    logic       exp_sel;
    logic       exp_conf;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] btn);
    {cancel_b, confirm_b, next_b} = btn;
  endtask

  task automatic press(input logic [2:0] btn, input int hold);
    drive(btn);
    for (int i = 0; i < hold; i++) tick();
    drive(3'b000);
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic wait_selecting(input string name);
    int k;
    k = 0;
    while (selecting !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check(name, selecting, 1'b1);
  endtask

  initial begin
    vecs.push_back('{3'b001, 10, 3'b001, 1'b1, 1'b0});
    vecs.push_back('{3'b001, 10, 3'b011, 1'b1, 1'b0});
    vecs.push_back('{3'b001, 10, 3'b101, 1'b1, 1'b0});
    vecs.push_back('{3'b001, 10, 3'b110, 1'b1, 1'b0});
    vecs.push_back('{3'b001, 10, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{3'b001, 10, 3'b001, 1'b1, 1'b0});
    vecs.push_back('{3'b001, 10, 3'b011, 1'b1, 1'b0});
    vecs.push_back('{3'b010, 10, 3'b011, 1'b0, 1'b1});
    vecs.push_back('{3'b001, 10, 3'b011, 1'b0, 1'b1});
    vecs.push_back('{3'b010, 10, 3'b011, 1'b0, 1'b1});
    vecs.push_back('{3'b100, 10, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{3'b010, 10, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{3'b100, 10, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{3'b001,  1, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{3'b001,  2, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{3'b001,  3, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{3'b001,  4, 3'b001, 1'b1, 1'b0});
    vecs.push_back('{3'b011, 10, 3'b001, 1'b0, 1'b1});
    vecs.push_back('{3'b101, 10, 3'b000, 1'b0, 1'b0});

    rst = 1'b1;
    drive(3'b000);
    for (int i = 0; i < 3; i++) tick();

    // Reset state.
    check("rst_user", user, 3'b000);
    check("rst_sel", selecting, 1'b0);
    check("rst_conf", confirmed, 1'b0);
    check("rst_pulse", confirm_pulse, 1'b0);
    rst = 1'b0;

    // Fifty idle cycles.
    for (int i = 0; i < 50; i++) tick();
    check("idle_user", user, 3'b000);
    check("idle_sel", selecting, 1'b0);
    check("idle_conf", confirmed, 1'b0);
    check("idle_no_pulse", pulse_total, 0);

    // Latency: Selecting rises exactly 8 cycles after the raw rise.
    next_b = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("lat_sel_before", selecting, 1'b0);
    tick();
    check("lat_sel_at8", selecting, 1'b1);
    check("lat_user", user, 3'b001);

    // Timeout: back to IDLE exactly 1000 cycles after entering SELECT.
    for (int t = 0; t < 999; t++) begin
      if (t == 2) next_b = 1'b0;
      tick();
    end
    check("tmo_sel_999", selecting, 1'b1);
    tick();
    check("tmo_sel_1000", selecting, 1'b0);
    check("tmo_user", user, 3'b000);

    // Table of single presses with settled results.
    foreach (vecs[i]) begin
      press(vecs[i].btn, vecs[i].hold);
      check($sformatf("vec%0d_user", i), user, vecs[i].exp_user);
      check($sformatf("vec%0d_sel", i), selecting, vecs[i].exp_sel);
      check($sformatf("vec%0d_conf", i), confirmed, vecs[i].exp_conf);
    end
    exp_pulses += 2;

    // A Next about 500 cycles into SELECT restarts the timeout.
    begin
      int k;
      logic [2:0] old_user;
      drive(3'b001);
      wait_selecting("rst_tmo_enter");
      for (int t = 0; t < 490; t++) begin
        if (t == 10) drive(3'b000);
        tick();
      end
      old_user = user;
      drive(3'b001);
      k = 0;
      while (user === old_user && k < 20) begin
        tick();
        k++;
      end
      drive(3'b000);
      check("rst_tmo_adv", user, 3'b011);
      for (int t = 0; t < 999; t++) tick();
      check("rst_tmo_sel_999", selecting, 1'b1);
      tick();
      check("rst_tmo_sel_1000", selecting, 1'b0);
    end

    // Confirm pulse lasts exactly one cycle; then reset while CONFIRMED.
    begin
      int k;
      press(3'b001, 10);
      check("cp_sel", selecting, 1'b1);
      drive(3'b010);
      k = 0;
      while (confirmed !== 1'b1 && k < 20) begin
        tick();
        k++;
      end
      check("cp_conf", confirmed, 1'b1);
      check("cp_pulse_first", confirm_pulse, 1'b1);
      check("cp_user", user, 3'b001);
      tick();
      check("cp_pulse_second", confirm_pulse, 1'b0);
      check("cp_conf_hold", confirmed, 1'b1);
      drive(3'b000);
      exp_pulses += 1;
      for (int i = 0; i < 12; i++) tick();
      drive(3'b100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_user", user, 3'b000);
      check("midrst_sel", selecting, 1'b0);
      check("midrst_conf", confirmed, 1'b0);
      check("midrst_pulse", confirm_pulse, 1'b0);
      drive(3'b000);
      for (int i = 0; i < 12; i++) tick();
    end

    // Confirm and Cancel in the same cycle while selecting: Cancel wins.
    press(3'b001, 10);
    check("cc_sel", selecting, 1'b1);
    press(3'b110, 10);
    check("cc_user", user, 3'b000);
    check("cc_sel_after", selecting, 1'b0);
    check("cc_conf", confirmed, 1'b0);

    // A Next held through reset release gives exactly one event.
    drive(3'b001);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("held_sel", selecting, 1'b1);
    check("held_user", user, 3'b001);
    for (int i = 0; i < 10; i++) tick();
    check("held_user_stable", user, 3'b001);
    drive(3'b000);
    for (int i = 0; i < 12; i++) tick();
    check("held_release_user", user, 3'b001);

    check("no_invalid_code", bad_code, 0);
    check("pulse_count", pulse_total, exp_pulses);
    check("pulse_only_confirmed", pulse_outside, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/codificador_de_usuario.md
Name: codificador_de_usuario

Overview:
- Sequential user-selection encoder: turns three push-button inputs into the 3-bit User code consumed by the seven-segment display decoder.
- Synchronises and debounces the buttons, then runs a select/confirm/cancel state machine. The state machine cycles only through valid user codes and latches the confirmed user.
- Sits between the board buttons and the display/access-control logic. Its User output drives the decoder's User input directly.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronised button level must hold before the debounced level changes (legal range 1..255).
- TIMEOUT_CYCLES, default 1000: idle cycles in SELECT before automatic return to IDLE (legal range 1..65535).
- BLINK_CYCLES, default 8: half-period of the selection blink; used only with BLINK_EN.

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Next  input  1  raw button, active-high, asynchronous to Clock: advance candidate.
- Confirm  input  1  raw button, active-high, asynchronous: accept candidate.
- Cancel  input  1  raw button, active-high, asynchronous: abort/logout.
- User  output  3  user code to the display decoder. 000 = neutral (blank), 001 = user, 011 = tester, 101 = admin, 110 = guest, 111 = autopilot.
- Selecting  output  1  high while in SELECT.
- Confirmed  output  1  high while in CONFIRMED.
- ConfirmPulse  output  1  one-cycle pulse on entry to CONFIRMED.

Behaviour:
- Reset (synchronous, Reset high at a rising edge):
  - state=IDLE, User=000, Selecting=0, Confirmed=0, ConfirmPulse=0.
  - Synchronisers, debounced levels, debounce counters, timeout counter and candidate register all cleared (candidate=001).
  - Reset asserted mid-operation overrides everything, including same-cycle button events.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter increments while the synchronised level differs from the debounced level and clears when they agree. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Event = one-cycle pulse on a debounced 0->1 transition.
  - Required latency: a clean raw rise held steady produces its event exactly DEBOUNCE_CYCLES+3 cycles later.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
  - Release produces no event.
  - A button held through reset release yields one event after debounce.
- Event priority in the same cycle: Cancel > Confirm > Next. Lower-priority events in that cycle are dropped.
- IDLE: User=000.
  - Next: candidate=001, go to SELECT.
  - Confirm and Cancel: ignored.
- SELECT: User=candidate, Selecting=1.
  - Next: advance along 001 -> 011 -> 101 -> 110 -> 111 -> 001 (wrap). Invalid codes 010 and 100 are never produced.
  - Confirm: latch candidate, go to CONFIRMED.
  - Cancel: go to IDLE.
  - Timeout counter clears on entry and on any event. When it reaches TIMEOUT_CYCLES, go to IDLE.
- CONFIRMED: User=latched code, Confirmed=1.
  - ConfirmPulse=1 on the first cycle only.
  - Next and Confirm: ignored.
  - Cancel: go to IDLE (logout). No timeout in this state.
- All outputs are registered, so each output changes in the cycle after the event that causes it.

Optional Feature:
- Macro: BLINK_EN.
- Defined:
  - In SELECT, User alternates between candidate and 000 every BLINK_CYCLES cycles, starting with candidate.
  - The blink phase counter restarts on every SELECT entry and on every Next, so the new candidate is shown immediately.
  - IDLE and CONFIRMED are unaffected.
- Undefined:
  - User holds the candidate steadily in SELECT.
  - No blink counter is synthesised.

Test Plan:
- Reset, then no buttons for 50 cycles -> User=000, Selecting=0, Confirmed=0, ConfirmPulse never high.
- Next pulse held 10 cycles, DEBOUNCE_CYCLES=4 -> Selecting rises 8 cycles after the raw rise (7-cycle event latency plus 1 registered cycle), User=001. Five further Next presses -> 011, 101, 110, 111, 001; 010 and 100 are never seen.
- Next, Next, then Confirm -> User=011, Confirmed=1, ConfirmPulse high exactly 1 cycle. Next during CONFIRMED leaves User=011. Cancel -> User=000, Confirmed=0.
- Raw glitches of 1..3 cycles on Next (DEBOUNCE_CYCLES=4) -> no event, state stays IDLE.
- Enter SELECT, no further input, TIMEOUT_CYCLES=1000 -> return to IDLE after exactly 1000 cycles. A Next at cycle 500 restarts the count.
- Confirm and Cancel debounced events in the same cycle while in SELECT -> IDLE, User=000. Reset asserted while CONFIRMED -> all outputs 0 on the next cycle.
